// File: rtl/csel_pkg.sv
// Shared types and elaboration helpers for the carry-select pipelined adder.
package csel_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } csel_op_t;

    // Usable in localparam context: operand width must split into whole blocks.
    function automatic bit cfg_ok(input int unsigned width, input int unsigned blk);
        return (blk != 0) && ((width % blk) == 0);
    endfunction

endpackage

// File: rtl/csel_block.sv
// One carry-select slice: block sum and carry for both carry-in hypotheses.
module csel_block
    import csel_pkg::*;
#(
    parameter int unsigned BLK = 8
) (
    input  logic [BLK-1:0] a_blk,
    input  logic [BLK-1:0] b_blk,
    output logic [BLK-1:0] sum0,
    output logic           c0,
    output logic [BLK-1:0] sum1,
    output logic           c1
);

    localparam int unsigned BW = BLK + 1;

    assign {c0, sum0} = BW'(a_blk) + BW'(b_blk);
    assign {c1, sum1} = BW'(a_blk) + BW'(b_blk) + BW'(1'b1);

endmodule

// File: rtl/csel_pipe_adder.sv
// Two-stage carry-select add/sub with elastic valid/ready flow and optional
// duplicate-adder self-check.
module csel_pipe_adder
    import csel_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned BLK   = 8,
    parameter int unsigned CHECK = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             c_out,
    output logic             ovf,
    output logic             err
);

    localparam bit          CFG_OK = cfg_ok(WIDTH, BLK);
    localparam int unsigned NBLK   = WIDTH / BLK;
    localparam int unsigned SW     = WIDTH + 1;

    if (!CFG_OK) begin : g_bad_cfg
        $error("csel_pipe_adder: WIDTH must be a non-zero multiple of BLK");
    end

    csel_op_t               op_e;
    logic [WIDTH-1:0]       b_eff_c;
    logic [NBLK-1:0][BLK-1:0] sum0_c, sum1_c;
    logic [NBLK-1:0]        c0_c, c1_c;

    logic                   v1;
    logic [NBLK-1:0][BLK-1:0] s1_sum0, s1_sum1;
    logic [NBLK-1:0]        s1_c0, s1_c1;
    logic                   s1_cin, s1_a_msb, s1_b_msb;

    logic                   s1_adv, s2_adv, s1_load, s2_load;
    logic [WIDTH-1:0]       res_sum_c;
    logic                   res_cout_c, res_ovf_c, carry_c;
    logic                   err_q;

    assign op_e    = csel_op_t'(op);
    assign b_eff_c = (op_e == OP_SUB) ? ~b : b;

    for (genvar i = 0; i < NBLK; i++) begin : g_blk
        csel_block #(.BLK(BLK)) u_blk (
            .a_blk (a[i*BLK +: BLK]),
            .b_blk (b_eff_c[i*BLK +: BLK]),
            .sum0  (sum0_c[i]),
            .c0    (c0_c[i]),
            .sum1  (sum1_c[i]),
            .c1    (c1_c[i])
        );
    end

    // Elastic handshake: each stage advances when it is empty or its consumer moves.
    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !v1 || s2_adv;
    assign in_ready = s1_adv;
    assign s1_load  = in_valid && s1_adv;
    assign s2_load  = v1 && s2_adv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1       <= 1'b0;
            s1_sum0  <= '0;
            s1_sum1  <= '0;
            s1_c0    <= '0;
            s1_c1    <= '0;
            s1_cin   <= 1'b0;
            s1_a_msb <= 1'b0;
            s1_b_msb <= 1'b0;
        end else begin
            if (s1_adv) v1 <= in_valid;
            if (s1_load) begin
                s1_sum0  <= sum0_c;
                s1_sum1  <= sum1_c;
                s1_c0    <= c0_c;
                s1_c1    <= c1_c;
                s1_cin   <= c_in;
                s1_a_msb <= a[WIDTH-1];
                s1_b_msb <= b_eff_c[WIDTH-1];
            end
        end
    end

    // Carry resolution: each block picks its precomputed pair by the previous block's carry.
    always_comb begin
        res_sum_c = '0;
        carry_c   = s1_cin;
        for (int i = 0; i < NBLK; i++) begin
            res_sum_c[i*BLK +: BLK] = carry_c ? s1_sum1[i] : s1_sum0[i];
            carry_c                 = carry_c ? s1_c1[i] : s1_c0[i];
        end
        res_cout_c = carry_c;
        res_ovf_c  = (s1_a_msb == s1_b_msb) && (res_sum_c[WIDTH-1] != s1_a_msb);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            s         <= '0;
            c_out     <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            if (s2_adv) out_valid <= v1;
            if (s2_load) begin
                s     <= res_sum_c;
                c_out <= res_cout_c;
                ovf   <= res_ovf_c;
            end
        end
    end

    if (CHECK != 0) begin : g_chk
        logic [WIDTH-1:0] s1_a, s1_b;
        logic [WIDTH:0]   ref_c;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s1_a <= '0;
                s1_b <= '0;
            end else if (s1_load) begin
                s1_a <= a;
                s1_b <= b_eff_c;
            end
        end

        assign ref_c = SW'(s1_a) + SW'(s1_b) + SW'(s1_cin);

        // Sticky: once a mismatch is loaded only reset clears it.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                err_q <= 1'b0;
            end else if (s2_load && (ref_c != {res_cout_c, res_sum_c})) begin
                err_q <= 1'b1;
            end
        end
    end else begin : g_nochk
        assign err_q = 1'b0;
    end

    assign err = err_q;

endmodule

// File: tb/tb_csel_pipe_adder.sv
// Directed bench for csel_pipe_adder (WIDTH=8, BLK=4, CHECK=1) with an
// arithmetic reference model and a per-cycle output compare.
module tb_csel_pipe_adder;
    import csel_pkg::*;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_ready;
    logic [W-1:0] a, b;
    logic         c_in, op;
    logic         out_valid, out_ready;
    logic [W-1:0] s;
    logic         c_out, ovf, err;

    csel_pipe_adder #(.WIDTH(W), .BLK(4), .CHECK(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .c_out     (c_out),
        .ovf       (ovf),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] s;
        logic         c_out;
        logic         ovf;
        logic         inj;
    } exp_t;

    exp_t         exp_q[$];
    logic [W-1:0] popped_s[$];
    logic         model_err;
    logic         inj_mark;
    int           n_checks;
    int           n_fails;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: unsigned sum for s/c_out, signed-range test for overflow.
    function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                   input logic ci, input logic opv, input logic inj);
        exp_t        e;
        int unsigned beff, tot;
        int          sa, sb, ssum;
        beff = opv ? (255 - int'(bv)) : int'(bv);
        tot  = int'(av) + beff + int'(ci);
        sa   = (av >= 128) ? int'(av) - 256 : int'(av);
        sb   = (beff >= 128) ? int'(beff) - 256 : int'(beff);
        ssum = sa + sb + int'(ci);
        e.s     = 8'(tot);
        e.c_out = (tot > 255);
        e.ovf   = (ssum > 127) || (ssum < -128);
        e.inj   = inj;
        // Injected fault claims block 1 carries out under carry-in 1.
        if (inj) e.c_out = 1'b1;
        return e;
    endfunction

    always @(negedge rst_n) begin
        exp_q.delete();
        model_err = 1'b0;
    end

    // Output compare, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_out_valid", 32'(out_valid), 32'd0);
                end else begin
                    if (exp_q[0].inj) model_err = 1'b1;
                    chk("cmp_s",     32'(s),     32'(exp_q[0].s));
                    chk("cmp_c_out", 32'(c_out), 32'(exp_q[0].c_out));
                    chk("cmp_ovf",   32'(ovf),   32'(exp_q[0].ovf));
                    chk("cmp_err",   32'(err),   32'(model_err));
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        popped_s.push_back(s);
                    end
                end
            end
            if (in_valid && in_ready)
                exp_q.push_back(model(a, b, c_in, op, inj_mark));
        end
    end

    task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic ci, input logic opv);
        int n;
        n = 0;
        in_valid = 1'b1; a = av; b = bv; c_in = ci; op = opv;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) chk("send_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Presented after edge k, captured at k+1, visible after k+2.
    task automatic run_vec(input string name, input logic [W-1:0] av, input logic [W-1:0] bv,
                           input logic ci, input logic opv,
                           input logic [W-1:0] es, input logic ec, input logic eo);
        send(av, bv, ci, opv);
        chk({name, "_early_valid"}, 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        chk({name, "_valid"}, 32'(out_valid), 32'd1);
        chk({name, "_s"},     32'(s),         32'(es));
        chk({name, "_c_out"}, 32'(c_out),     32'(ec));
        chk({name, "_ovf"},   32'(ovf),       32'(eo));
    endtask

    initial begin
        int n_out;
        n_checks = 0; n_fails = 0;
        model_err = 1'b0; inj_mark = 1'b0;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; c_in = 1'b0; op = OP_ADD;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_s",         32'(s),         32'd0);
        chk("rst_err",       32'(err),       32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b1;

        run_vec("add_wrap", 8'hFF, 8'h01, 1'b0, OP_ADD, 8'h00, 1'b1, 1'b0);
        run_vec("add_ovf",  8'h7F, 8'h01, 1'b0, OP_ADD, 8'h80, 1'b0, 1'b1);
        run_vec("sub_ovf",  8'h80, 8'h01, 1'b1, OP_SUB, 8'h7F, 1'b1, 1'b1);
        run_vec("sub_zero", 8'h05, 8'h05, 1'b1, OP_SUB, 8'h00, 1'b1, 1'b0);
        run_vec("sub_brw",  8'h03, 8'h05, 1'b1, OP_SUB, 8'hFE, 1'b0, 1'b0);

        // Back-to-back stream at full rate; the compare process checks each.
        send(8'h0F, 8'h01, 1'b0, OP_ADD);
        send(8'hF0, 8'h10, 1'b1, OP_ADD);
        send(8'h55, 8'hAA, 1'b1, OP_ADD);
        send(8'h00, 8'h01, 1'b1, OP_SUB);
        send(8'h7F, 8'hFF, 1'b1, OP_SUB);
        send(8'h3C, 8'hC3, 1'b0, OP_SUB);
        repeat (4) @(posedge clk);
        #1;
        chk("stream_drained", 32'(exp_q.size()), 32'd0);

        // Backpressure: two entries fill, the third waits.
        popped_s.delete();
        out_ready = 1'b0;
        in_valid = 1'b1; a = 8'd1; b = 8'd1; c_in = 1'b0; op = OP_ADD;
        @(posedge clk); #1;
        chk("bp_ready_after_1", 32'(in_ready), 32'd1);
        a = 8'd2; b = 8'd2;
        @(posedge clk); #1;
        a = 8'd3; b = 8'd3;
        chk("bp_ready_drop", 32'(in_ready), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("bp_ready_held", 32'(in_ready),  32'd0);
        chk("bp_hold_valid", 32'(out_valid), 32'd1);
        chk("bp_hold_s",     32'(s),         32'd2);
        out_ready = 1'b1;
        #1;
        chk("bp_ready_comb", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("bp_count", 32'(popped_s.size()), 32'd3);
        if (popped_s.size() == 3) begin
            chk("bp_order0", 32'(popped_s[0]), 32'd2);
            chk("bp_order1", 32'(popped_s[1]), 32'd4);
            chk("bp_order2", 32'(popped_s[2]), 32'd6);
        end

        // Self-check: corrupt block 1's carry-in-1 carry while 0F+01 is captured.
        force dut.g_blk[1].u_blk.c1 = 1'b1;
        inj_mark = 1'b1;
        send(8'h0F, 8'h01, 1'b0, OP_ADD);
        release dut.g_blk[1].u_blk.c1;
        inj_mark = 1'b0;
        chk("inj_err_before", 32'(err), 32'd0);
        @(posedge clk); #1;
        chk("inj_valid", 32'(out_valid), 32'd1);
        chk("inj_s",     32'(s),         32'h10);
        chk("inj_err",   32'(err),       32'd1);
        run_vec("post_inj1", 8'h22, 8'h11, 1'b0, OP_ADD, 8'h33, 1'b0, 1'b0);
        chk("err_sticky1", 32'(err), 32'd1);
        run_vec("post_inj2", 8'h50, 8'h10, 1'b1, OP_SUB, 8'h40, 1'b1, 1'b0);
        chk("err_sticky2", 32'(err), 32'd1);
        @(posedge clk); #1;

        // Reset with two transactions buffered.
        out_ready = 1'b0;
        send(8'h10, 8'h20, 1'b0, OP_ADD);
        send(8'h30, 8'h40, 1'b0, OP_ADD);
        chk("mid_valid_pre", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_s",     32'(s),         32'd0);
        chk("mid_rst_c_out", 32'(c_out),     32'd0);
        chk("mid_rst_ovf",   32'(ovf),       32'd0);
        chk("mid_rst_err",   32'(err),       32'd0);
        @(negedge clk) rst_n = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("mid_rel_ready", 32'(in_ready), 32'd1);
        n_out = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (out_valid) n_out++;
        end
        chk("mid_no_emit", 32'(n_out), 32'd0);
        run_vec("recover", 8'h12, 8'h34, 1'b0, OP_ADD, 8'h46, 1'b0, 1'b0);
        chk("recover_err", 32'(err), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("final_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
